// File: rtl/rv32i_fetch_pkg.sv
// Shared constants and types for the rv32i fetch stage.
package rv32i_fetch_pkg;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0]   PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_beat_t;
endpackage

// File: rtl/rv32i_fetch_if.sv
// ROM and decode-side signals of the fetch stage.
interface rv32i_fetch_if;
  import rv32i_fetch_pkg::*;

  logic [XLEN-1:0]   iaddr;
  logic [INST_W-1:0] inst;
  logic              i_stall;
  logic              i_flush;
  logic [XLEN-1:0]   i_flush_pc;
  logic              o_valid;
  logic [XLEN-1:0]   o_pc;
  logic [INST_W-1:0] o_inst;

  modport master (
    output iaddr,
    input  inst,
    input  i_stall,
    input  i_flush,
    input  i_flush_pc,
    output o_valid,
    output o_pc,
    output o_inst
  );

  modport slave (
    input  iaddr,
    output inst,
    output i_stall,
    output i_flush,
    output i_flush_pc,
    input  o_valid,
    input  o_pc,
    input  o_inst
  );
endinterface

// File: rtl/rv32i_fetch_skid.sv
// One-entry {pc, inst} buffer holding a ROM beat that arrived while decode stalled.
module rv32i_fetch_skid
  import rv32i_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr,
  input  logic        rd,
  input  fetch_beat_t din,
  output fetch_beat_t dout,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (clr)      valid <= 1'b0;
      else if (wr)  valid <= 1'b1;
      else if (rd)  valid <= 1'b0;
      if (wr && !clr) dout <= din;
    end
  end

endmodule

// File: rtl/rv32i_fetch.sv
// Instruction fetch: drives the ROM address, absorbs its 1-cycle latency and
// presents {valid, pc, inst} to decode with stall back-pressure and flush redirect.
module rv32i_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  rv32i_fetch_if.master bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            out_valid;
  fetch_beat_t     out_q;
  fetch_beat_t     skid_dout;
  logic            skid_valid;
  logic            pop, load, issue, skid_wr, skid_rd;
  logic [1:0]      occupancy;
  logic            unused_flush_lo;

  // Handshake: decode takes o_pc/o_inst at an edge where o_valid=1 and i_stall=0;
  // while i_stall=1 the outputs are frozen, and i_flush overrides both.
  assign pop  = out_valid & ~bus.i_stall;
  assign load = ~out_valid | pop;

  // Beats already owned (output, skid, ROM in flight) after this edge's pop;
  // at most two may be held, so the skid can never overflow.
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight} - {1'b0, pop};
  assign issue     = ~bus.i_flush & (occupancy < 2'd2);

  assign skid_wr = inflight & out_valid & bus.i_stall & ~bus.i_flush;
  assign skid_rd = load & skid_valid & ~bus.i_flush;

  rv32i_fetch_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.i_flush),
    .wr    (skid_wr),
    .rd    (skid_rd),
    .din   ('{pc: inflight_pc, inst: bus.inst}),
    .dout  (skid_dout),
    .valid (skid_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_RESET;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.i_flush) begin
      pc_q     <= {bus.i_flush_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc_q        <= pc_q + PC_INC;
      inflight    <= 1'b1;
      inflight_pc <= pc_q;
    end else begin
      inflight <= 1'b0;
    end
  end

  // Skid content is older than the in-flight beat, so it is drained first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '{pc: '0, inst: NOP};
    end else if (bus.i_flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_q     <= skid_dout;
      end else if (inflight) begin
        out_valid <= 1'b1;
        out_q     <= '{pc: inflight_pc, inst: bus.inst};
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign unused_flush_lo = ^bus.i_flush_pc[1:0];

  assign bus.iaddr   = pc_q;
  assign bus.o_valid = out_valid;
  assign bus.o_pc    = out_q.pc;
  assign bus.o_inst  = out_q.inst;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed and randomised checks of rv32i_fetch against a ROM model and an in-order pc scoreboard.
module tb_rv32i_fetch;
  import rv32i_fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   pops;
  logic [31:0] exp_q[$];

  rv32i_fetch_if bus ();
  rv32i_fetch_if bus2 ();

  rv32i_fetch #(.PC_RESET(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  rv32i_fetch #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF ^ {16'h0, a[31:16]};
  endfunction

  // ROM with one-cycle read latency
  always @(posedge clk) begin
    bus.inst  <= rom_word(bus.iaddr);
    bus2.inst <= rom_word(bus2.iaddr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'h0, bus.o_valid}, 32'h1);
    check({tag, "_pc"}, bus.o_pc, pc);
    check({tag, "_inst"}, bus.o_inst, rom_word(pc));
  endtask

  task automatic drive(input logic stall, input logic flush, input logic [31:0] fpc);
    bus.i_stall    = stall;
    bus.i_flush    = flush;
    bus.i_flush_pc = fpc;
  endtask

  initial begin
    logic        held;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic        stall;
    logic        flush;
    logic [31:0] fpc;
    logic [31:0] exp_pc;

    tests = 0;
    fails = 0;
    pops  = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    bus2.i_stall    = 1'b0;
    bus2.i_flush    = 1'b0;
    bus2.i_flush_pc = 32'h0;

    // reset state
    tick();
    tick();
    check("rst_iaddr", bus.iaddr, 32'h0);
    check("rst_valid", {31'h0, bus.o_valid}, 32'h0);
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_inst", bus.o_inst, NOP);
    check("rst_wrap_iaddr", bus2.iaddr, 32'hFFFF_FFF8);

    // first fetches and pc wrap
    rst_n = 1'b1;
    tick();
    check("start_edge1_valid", {31'h0, bus.o_valid}, 32'h0);
    tick();
    check_out("start0", 32'h0);
    check("wrap0", bus2.o_pc, 32'hFFFF_FFF8);
    tick();
    check_out("start4", 32'h4);
    check("wrap1", bus2.o_pc, 32'hFFFF_FFFC);
    tick();
    check_out("start8", 32'h8);
    check("wrap2", bus2.o_pc, 32'h0000_0000);
    check("wrap2_inst", bus2.o_inst, rom_word(32'h0));

    // stall for three cycles at pc 0x8
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall_hold", 32'h8);
      check("stall_iaddr", bus.iaddr, 32'h10);
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check_out("release_c", 32'hC);
    tick();
    check_out("release_10", 32'h10);
    tick();
    check_out("release_14", 32'h14);

    // flush with stall, unaligned target
    drive(1'b1, 1'b1, 32'h2E);
    tick();
    check("flush_valid", {31'h0, bus.o_valid}, 32'h0);
    check("flush_iaddr", bus.iaddr, 32'h2C);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("flush_edge1_valid", {31'h0, bus.o_valid}, 32'h0);
    tick();
    check_out("flush_2c", 32'h2C);
    tick();
    check_out("flush_30", 32'h30);

    // fill the skid, then back-to-back flushes
    drive(1'b1, 1'b0, 32'h0);
    tick();
    check_out("skid_hold0", 32'h30);
    check("skid_iaddr0", bus.iaddr, 32'h38);
    tick();
    check_out("skid_hold1", 32'h30);
    check("skid_iaddr1", bus.iaddr, 32'h38);
    drive(1'b1, 1'b1, 32'h40);
    tick();
    check("b2b_iaddr0", bus.iaddr, 32'h40);
    check("b2b_valid0", {31'h0, bus.o_valid}, 32'h0);
    drive(1'b0, 1'b1, 32'h80);
    tick();
    check("b2b_iaddr1", bus.iaddr, 32'h80);
    check("b2b_valid1", {31'h0, bus.o_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("b2b_edge1_valid", {31'h0, bus.o_valid}, 32'h0);
    tick();
    check_out("b2b_80", 32'h80);
    tick();
    check_out("b2b_84", 32'h84);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_iaddr", bus.iaddr, 32'h0);
    check("async_rst_valid", {31'h0, bus.o_valid}, 32'h0);
    check("async_rst_pc", bus.o_pc, 32'h0);
    check("async_rst_inst", bus.o_inst, NOP);
    tick();
    rst_n = 1'b1;
    tick();
    check("rerun_edge1_valid", {31'h0, bus.o_valid}, 32'h0);
    tick();
    check_out("rerun0", 32'h0);
    tick();
    check_out("rerun4", 32'h4);
    tick();
    check_out("rerun8", 32'h8);

    // random stall/flush against the pc scoreboard
    exp_q.delete();
    exp_q.push_back(32'h8);
    held      = 1'b0;
    prev_pc   = 32'h0;
    prev_inst = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (held) begin
        check("hold_valid", {31'h0, bus.o_valid}, 32'h1);
        check("hold_pc", bus.o_pc, prev_pc);
        check("hold_inst", bus.o_inst, prev_inst);
      end
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 31) == 0);
      fpc   = $urandom_range(0, 32'h0000_0FFF);
      drive(stall, flush, fpc);
      if (flush) begin
        exp_q.delete();
        exp_q.push_back({fpc[31:2], 2'b00});
      end else if (bus.o_valid && !stall) begin
        exp_pc = exp_q.pop_front();
        check("sb_pc", bus.o_pc, exp_pc);
        check("sb_inst", bus.o_inst, rom_word(exp_pc));
        exp_q.push_back(exp_pc + 32'd4);
        pops++;
      end
      held      = bus.o_valid & stall & ~flush;
      prev_pc   = bus.o_pc;
      prev_inst = bus.o_inst;
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    check("sb_pop_rate", {31'h0, (pops > 1000)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
